// File: rtl/line_window_3x3_if.sv
// -----------------------------------------------------------------------------
// line_window_3x3_if
// Pixel-stream in / 3x3 window out bundle for the neighbourhood generator.
//   sof, pix_valid, pix_in : raster-order pixel stream (driven by master)
//   win_valid, win         : registered 3x3 window, k = 3*r + c at [k*N +: N]
//   win_last               : marks the final window of a frame
//   ovf                    : sticky overflow (pixels past W*H without a sof)
// master = pixel source / window consumer, slave = line_window_3x3.
// -----------------------------------------------------------------------------
interface line_window_3x3_if #(
  parameter int N = 8
);
  logic           sof;
  logic           pix_valid;
  logic [N-1:0]   pix_in;
  logic           win_valid;
  logic [9*N-1:0] win;
  logic           win_last;
  logic           ovf;

  modport master (
    output sof, pix_valid, pix_in,
    input  win_valid, win, win_last, ovf
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output win_valid, win, win_last, ovf
  );
endinterface

// File: rtl/line_window_3x3.sv
// -----------------------------------------------------------------------------
// line_window_3x3
// Buffers the two previous lines of a raster pixel stream and emits a
// registered 3x3 window for every interior pixel position, one cycle after
// the pixel that completes the window is accepted.
//   clk : system clock, rising edge
//   rst : synchronous reset, active-high
//   bus : line_window_3x3_if.slave (stream in, window out)
// Parameters: N pixel width, W pixels per line, H lines per frame (W,H >= 3).
// -----------------------------------------------------------------------------
module line_window_3x3 #(
  parameter int N = 8,
  parameter int W = 64,
  parameter int H = 48
) (
  input  logic               clk,
  input  logic               rst,
  line_window_3x3_if.slave   bus
);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          frame_active;
  logic          frame_done;   // a frame completed since the last sof/reset
  logic          ovf_q;
  logic          win_valid_q, win_last_q;
  logic [N-1:0]  win_q [9];

  logic [N-1:0]  linebuf0 [W]; // previous line
  logic [N-1:0]  linebuf1 [W]; // line before that

  logic          take;
  logic          col_end, row_end, last_pix, emit;
  logic [N-1:0]  lb0_rd, lb1_rd;

  // A sof pixel is always position (0,0), whatever col/row held before.
  // NOTE: every signal driven here gets a value on every path, so no latch.
  always_comb begin
    take     = bus.pix_valid && (bus.sof || frame_active);
    cur_col  = bus.sof ? '0 : col;
    cur_row  = bus.sof ? '0 : row;
    col_end  = (cur_col == CW'(W - 1));
    row_end  = (cur_row == RW'(H - 1));
    last_pix = col_end && row_end;
    // col < 2 keeps the previous line's right edge out of the window.
    emit     = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    // Read before the same-address write below takes effect.
    lb0_rd   = linebuf0[cur_col];
    lb1_rd   = linebuf1[cur_col];
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      ovf_q        <= 1'b0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      if (take) begin
        if (bus.sof) begin
          frame_active <= 1'b1;
          frame_done   <= 1'b0;
          ovf_q        <= 1'b0;
        end
        // Shift left one column; the new right column is oldest..newest line.
        for (int r = 0; r < 3; r++) begin
          win_q[3*r]     <= win_q[3*r + 1];
          win_q[3*r + 1] <= win_q[3*r + 2];
        end
        win_q[2] <= lb1_rd;
        win_q[5] <= lb0_rd;
        win_q[8] <= bus.pix_in;

        win_valid_q <= emit;
        win_last_q  <= emit && last_pix;

        if (last_pix) begin
          col          <= '0;
          row          <= '0;
          frame_active <= 1'b0;
          frame_done   <= 1'b1;
        end else if (col_end) begin
          col <= '0;
          row <= cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end else if (bus.pix_valid && frame_done) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // NOTE: line buffers hold only pixel data overwritten before use, so they
  // carry no reset and can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (take && !rst) begin
      linebuf1[cur_col] <= lb0_rd;
      linebuf0[cur_col] <= bus.pix_in;
    end
  end

  always_comb begin
    bus.win = '0;
    for (int k = 0; k < 9; k++) bus.win[k*N +: N] = win_q[k];
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_line_window_3x3.sv
// -----------------------------------------------------------------------------
// tb_line_window_3x3
// Directed stimulus for line_window_3x3 (N=8, W=8, H=4). Expected windows are
// queued as pixels are driven; a monitor pops and compares on each win_valid.
// -----------------------------------------------------------------------------
module tb_line_window_3x3;
  localparam int N = 8;
  localparam int W = 8;
  localparam int H = 4;

  typedef struct {
    logic [9*N-1:0] w;
    logic           last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_window_3x3_if #(.N(N)) bus ();

  line_window_3x3 #(.N(N), .W(W), .H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int             n_checks = 0;
  int             n_fail   = 0;
  exp_t           sb[$];
  logic [9*N-1:0] seen[$];
  int             win_total = 0;
  logic           pv_q = 1'b0;

  task automatic check(input string name, input logic [9*N-1:0] act,
                       input logic [9*N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9*N-1:0] pack9(input int a0, a1, a2, a3, a4,
                                            a5, a6, a7, a8);
    logic [9*N-1:0] w;
    w = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    return w;
  endfunction

  // Window whose newest pixel is (r,c) in a frame with pixel value base+r*W+c.
  function automatic logic [9*N-1:0] model_win(input int base, r, c);
    logic [9*N-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i + j)*N +: N] = 8'(base + (r - 2 + i)*W + (c - 2 + j));
    return w;
  endfunction

  task automatic step(input logic s, input logic pv, input logic [N-1:0] v);
    @(posedge clk);
    #2;
    bus.sof       = s;
    bus.pix_valid = pv;
    bus.pix_in    = v;
  endtask

  task automatic send(input int base, input int idx, input logic s);
    int   r, c;
    exp_t e;
    r = idx / W;
    c = idx % W;
    if (r >= 2 && c >= 2) begin
      e.w    = model_win(base, r, c);
      e.last = (idx == W*H - 1);
      sb.push_back(e);
    end
    step(s, 1'b1, 8'(base + idx));
  endtask

  task automatic frame(input int base, input int from, input int to,
                       input bit gaps);
    for (int i = from; i < to; i++) begin
      send(base, i, i == 0);
      if (gaps) step(1'b0, 1'b0, '0);
    end
  endtask

  task automatic drain();
    step(1'b0, 1'b0, '0);
    for (int t = 0; t < 20; t++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain_all_windows_seen", 72'(sb.size()), 72'd0);
  endtask

  // Monitor: pix_valid as sampled by the DUT on the last rising edge.
  always @(posedge clk) pv_q <= bus.pix_valid;

  always @(negedge clk) begin
    exp_t e;
    if (!pv_q) begin
      check("no_win_after_idle", 72'(bus.win_valid), 72'd0);
    end else if (bus.win_valid === 1'b1) begin
      check("win_expected", 72'(sb.size() > 0), 72'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("win", bus.win, e.w);
        check("win_last", 72'(bus.win_last), 72'(e.last));
      end
      seen.push_back(bus.win);
      win_total++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, s0;
    rst           = 1'b1;
    bus.sof       = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_win_valid", 72'(bus.win_valid), 72'd0);
    check("rst_win_last", 72'(bus.win_last), 72'd0);
    check("rst_ovf", 72'(bus.ovf), 72'd0);
    check("rst_win", bus.win, 72'd0);

    // Pixels before any sof are discarded.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(50 + i));
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check("discard_ovf", 72'(bus.ovf), 72'd0);
    check("discard_no_win", 72'(bus.win_valid), 72'd0);

    // Continuous frame.
    n0 = win_total; s0 = seen.size();
    frame(0, 0, W*H, 1'b0);
    drain();
    check("t1_count", 72'(win_total - n0), 72'd12);
    check("t1_first", seen[s0], pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    check("t1_last", seen[s0 + 11], pack9(13, 14, 15, 21, 22, 23, 29, 30, 31));

    // Same frame with one idle cycle after every pixel.
    n0 = win_total; s0 = seen.size();
    frame(0, 0, W*H, 1'b1);
    drain();
    check("t2_count", 72'(win_total - n0), 72'd12);
    check("t2_first", seen[s0], pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));

    // Restart at pixel 20 of a frame, then a full second frame.
    n0 = win_total; s0 = seen.size();
    frame(0, 0, 20, 1'b0);
    frame(100, 0, W*H, 1'b0);
    drain();
    check("t3_count", 72'(win_total - n0), 72'd14);
    check("t3_first_f2", seen[s0 + 2],
          pack9(100, 101, 102, 108, 109, 110, 116, 117, 118));

    // Overflow past the frame end, then cleared by sof.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'(200 + i));
      step(1'b0, 1'b0, '0);
      @(negedge clk);
      check("ovf_set", 72'(bus.ovf), 72'd1);
    end
    send(0, 0, 1'b1);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check("ovf_cleared_by_sof", 72'(bus.ovf), 72'd0);
    frame(0, 1, 21, 1'b0);

    // Reset right after pixel 20 is accepted.
    @(posedge clk);
    #2;
    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t5_rst_win_valid", 72'(bus.win_valid), 72'd0);
    check("t5_rst_win_last", 72'(bus.win_last), 72'd0);
    check("t5_rst_ovf", 72'(bus.ovf), 72'd0);
    check("t5_rst_win", bus.win, 72'd0);
    check("t5_queue_empty", 72'(sb.size()), 72'd0);

    n0 = win_total; s0 = seen.size();
    frame(0, 0, W*H, 1'b0);
    drain();
    check("t5_count", 72'(win_total - n0), 72'd12);
    check("t5_first", seen[s0], pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    check("t5_last", seen[s0 + 11], pack9(13, 14, 15, 21, 22, 23, 29, 30, 31));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
